// File: rtl/pixel_readout.sv
// -----------------------------------------------------------------------------
// pixel_readout
//   Readout stage that follows the pixel-state sequencer. It does three jobs:
//     * generates the ADC ramp code broadcast to the pixel comparators while
//       the sequencer is in its convert phase;
//     * watches the row-select pattern and, once a new pattern has been stable
//       for SETTLE cycles, captures both shared pixel-data lanes;
//     * queues the captured codes in a small FIFO and presents them as a
//       valid/ready stream of {sof, idx, data} words.
//
// Ports
//   clk        system clock, all logic on posedge
//   reset      synchronous, active-high
//   erase      sequencer erase phase (clears ramp, aborts any capture)
//   convert    sequencer convert phase (ramp counts up)
//   read       row select: 4'b1100 = pixels 3/2, 4'b0011 = pixels 1/0
//   pix_data   {lane1, lane0}: upper / lower selected pixel code
//   dac_code   ramp code to the pixel comparators
//   out_data   head-of-FIFO pixel code
//   out_idx    pixel index (3..0) of out_data
//   out_sof    high on the idx-3 word (first pixel of a frame)
//   out_valid  FIFO not empty
//   out_ready  consumer accepts; a word moves on out_valid & out_ready
//   overflow   sticky: a word was dropped because the FIFO was full
//   frame_done one-cycle pulse after the idx-0 word enters the FIFO
// -----------------------------------------------------------------------------
module pixel_readout #(
  parameter int W          = 8,
  parameter int SETTLE     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           erase,
  input  logic           convert,
  input  logic [3:0]     read,
  input  logic [2*W-1:0] pix_data,
  output logic [W-1:0]   dac_code,
  output logic [W-1:0]   out_data,
  output logic [1:0]     out_idx,
  output logic           out_sof,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           overflow,
  output logic           frame_done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [3:0] PAT_HI = 4'b1100;
  localparam logic [3:0] PAT_LO = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAP_HI,
    ST_CAP_LO
  } state_t;

  typedef struct packed {
    logic         sof;
    logic [1:0]   idx;
    logic [W-1:0] data;
  } word_t;

  // ---------------------------------------------------------------------------
  // Ramp generator: erase clears, convert counts up and sticks at full scale.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      dac_code <= '0;
    end else if (erase) begin
      dac_code <= '0;
    end else if (convert && (dac_code != '1)) begin
      dac_code <= dac_code + W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    pat_q, pat_d;
  logic [3:0]    read_prev;
  logic [W-1:0]  lane1_q, lane0_q;
  logic          cap_en;
  logic          push;
  word_t         push_word;
  logic          new_pat;
  logic          pat_is_hi;

  // A pattern only starts a capture on the cycle it first appears, so a row
  // select held for a long time produces exactly one pair of words.
  assign new_pat   = ((read == PAT_HI) || (read == PAT_LO)) && (read != read_prev);
  assign pat_is_hi = (pat_q == PAT_HI);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    cap_en    = 1'b0;
    push      = 1'b0;
    push_word = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (new_pat) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
          pat_d   = read;
        end
      end

      ST_SETTLE: begin
        if (read != pat_q) begin
          state_d = ST_IDLE;                 // pattern moved: abandon capture
        end else if (cnt_q == CW'(SETTLE - 1)) begin
          cap_en  = 1'b1;
          state_d = ST_CAP_HI;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_CAP_HI: begin
        push      = 1'b1;
        push_word = '{sof: pat_is_hi, idx: pat_is_hi ? 2'd3 : 2'd1, data: lane1_q};
        state_d   = ST_CAP_LO;
      end

      ST_CAP_LO: begin
        push      = 1'b1;
        push_word = '{sof: 1'b0, idx: pat_is_hi ? 2'd2 : 2'd0, data: lane0_q};
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Erase aborts whatever capture is in flight; queued words are untouched.
    if (erase) begin
      state_d = ST_IDLE;
      cap_en  = 1'b0;
      push    = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pat_q     <= '0;
      read_prev <= '0;
      lane1_q   <= '0;
      lane0_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      read_prev <= read;
      if (cap_en) begin
        lane1_q <= pix_data[2*W-1:W];
        lane0_q <= pix_data[W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  word_t         mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, pop, wr_en;
  word_t         head;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // only dropped when nothing is leaving.
  assign wr_en = push && (!full || pop);

  // NOTE: the storage array has no reset; stale entries are never visible
  // because the outputs are forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && !wr_en) overflow <= 1'b1;
      frame_done <= wr_en && (state_q == ST_CAP_LO) && !pat_is_hi;
    end
  end

  assign head      = mem[rd_ptr];
  assign out_valid = !empty;
  assign out_data  = out_valid ? head.data : '0;
  assign out_idx   = out_valid ? head.idx  : '0;
  assign out_sof   = out_valid ? head.sof  : 1'b0;

endmodule

// File: tb/tb_pixel_readout.sv
// -----------------------------------------------------------------------------
// tb_pixel_readout
//   Directed bench for pixel_readout (W=8, SETTLE=2, FIFO_DEPTH=4).
//   Inputs change 1 time unit after a rising edge; outputs are compared at the
//   same point, i.e. they reflect the state loaded by that rising edge.
// -----------------------------------------------------------------------------
module tb_pixel_readout;

  logic        clk = 1'b0;
  logic        reset;
  logic        erase;
  logic        convert;
  logic [3:0]  read;
  logic [15:0] pix_data;
  logic [7:0]  dac_code;
  logic [7:0]  out_data;
  logic [1:0]  out_idx;
  logic        out_sof;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [10:0] got[$];    // drained words {sof, idx, data}
  logic [10:0] exp_q[$];  // expected words for the next compare

  pixel_readout #(.W(8), .SETTLE(2), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .erase      (erase),
    .convert    (convert),
    .read       (read),
    .pix_data   (pix_data),
    .dac_code   (dac_code),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_sof    (out_sof),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [3:0] r, input logic [15:0] p, input int n);
    read     = r;
    pix_data = p;
    repeat (n) step();
  endtask

  // Pop every queued word (bounded), recording them in order.
  task automatic drain(input int max_cycles);
    got.delete();
    out_ready = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      if (!out_valid) break;
      got.push_back({out_sof, out_idx, out_data});
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic compare_words(input string name);
    check({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_w%0d", name, i), got[i], exp_q[i]);
    exp_q.delete();
  endtask

  typedef struct packed {
    logic [3:0]  read;
    logic [15:0] pix;
    logic        exp_valid;
    logic        exp_sof;
    logic [1:0]  exp_idx;
    logic [7:0]  exp_data;
    logic        exp_fd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // Stream vectors, out_ready=1: one row-select per cycle, expected
    // outputs right after that cycle's closing edge.
    vecs[0]  = '{4'b1100, 16'hA35C, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0};
    vecs[1]  = '{4'b1100, 16'hA35C, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0};
    vecs[2]  = '{4'b1100, 16'hA35C, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0};
    vecs[3]  = '{4'b1100, 16'hA35C, 1'b1, 1'b1, 2'd3, 8'hA3, 1'b0};
    vecs[4]  = '{4'b1100, 16'hA35C, 1'b1, 1'b0, 2'd2, 8'h5C, 1'b0};
    vecs[5]  = '{4'b1100, 16'hA35C, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0};
    vecs[6]  = '{4'b0011, 16'h1122, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0};
    vecs[7]  = '{4'b0011, 16'h1122, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0};
    vecs[8]  = '{4'b0011, 16'h1122, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0};
    vecs[9]  = '{4'b0011, 16'h1122, 1'b1, 1'b0, 2'd1, 8'h11, 1'b0};
    vecs[10] = '{4'b0011, 16'h1122, 1'b1, 1'b0, 2'd0, 8'h22, 1'b1};
    vecs[11] = '{4'b0011, 16'h1122, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0};

    reset = 1'b1; erase = 1'b0; convert = 1'b0; read = 4'b0000;
    pix_data = 16'h0000; out_ready = 1'b0;

    // ---------------- reset state ----------------
    step(); step();
    check("rst_dac",       dac_code,   32'd0);
    check("rst_valid",     out_valid,  32'd0);
    check("rst_word",      {out_sof, out_idx, out_data}, 32'd0);
    check("rst_overflow",  overflow,   32'd0);
    check("rst_framedone", frame_done, 32'd0);
    reset = 1'b0;
    step();

    // ---------------- ramp ----------------
    erase = 1'b1; step();
    check("ramp_erase", dac_code, 32'd0);
    erase = 1'b0; convert = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      step();
      check($sformatf("ramp_%0d", k), dac_code, (k > 255) ? 32'd255 : 32'(k));
    end
    convert = 1'b0; step();
    check("ramp_hold", dac_code, 32'd255);
    erase = 1'b1; step();
    check("ramp_erase_full", dac_code, 32'd0);
    erase = 1'b0; convert = 1'b1;
    repeat (5) step();
    check("ramp_5", dac_code, 32'd5);
    erase = 1'b1; step();
    check("ramp_erase_wins", dac_code, 32'd0);
    erase = 1'b0; convert = 1'b0;
    step(); step();

    // ---------------- streaming frame (table) ----------------
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      read     = vecs[i].read;
      pix_data = vecs[i].pix;
      step();
      check($sformatf("stream_v%0d", i),
            {out_valid, out_sof, out_idx, out_data, frame_done},
            {vecs[i].exp_valid, vecs[i].exp_sof, vecs[i].exp_idx,
             vecs[i].exp_data, vecs[i].exp_fd});
    end
    out_ready = 1'b0;
    apply(4'b0000, 16'h0000, 2);

    // ---------------- aborted / ignored patterns, held pattern ----------------
    apply(4'b1100, 16'hA35C, 2);
    apply(4'b0000, 16'h0000, 8);
    check("abort_no_push", out_valid, 32'd0);
    apply(4'b1010, 16'hA35C, 10);
    check("bad_pat_no_push", out_valid, 32'd0);
    apply(4'b1100, 16'hA35C, 20);
    drain(20);
    exp_q.push_back({1'b1, 2'd3, 8'hA3});
    exp_q.push_back({1'b0, 2'd2, 8'h5C});
    compare_words("held");
    check("held_empty", out_valid, 32'd0);
    apply(4'b0000, 16'h0000, 2);

    // ---------------- push and pop together while full ----------------
    apply(4'b1100, 16'hA35C, 6);
    apply(4'b0011, 16'h1122, 6);
    check("full_valid", out_valid, 32'd1);
    read = 4'b1100; pix_data = 16'h7788;
    repeat (3) step();             // settle; capture happens on the third cycle
    out_ready = 1'b1;
    step();                        // CAP_HI push coincides with a pop
    check("fullpp_head", {out_sof, out_idx, out_data}, {1'b0, 2'd2, 8'h5C});
    drain(20);
    exp_q.push_back({1'b0, 2'd2, 8'h5C});
    exp_q.push_back({1'b0, 2'd1, 8'h11});
    exp_q.push_back({1'b0, 2'd0, 8'h22});
    exp_q.push_back({1'b1, 2'd3, 8'h77});
    exp_q.push_back({1'b0, 2'd2, 8'h88});
    compare_words("fullpp");
    check("fullpp_overflow", overflow, 32'd0);
    apply(4'b0000, 16'h0000, 2);

    // ---------------- overflow: two frames with no consumer ----------------
    apply(4'b1100, 16'hA35C, 6);
    apply(4'b0011, 16'h1122, 6);
    check("ovf_exact_full", overflow, 32'd0);
    apply(4'b1100, 16'hDEAD, 6);
    apply(4'b0011, 16'hBEEF, 6);
    check("ovf_set", overflow, 32'd1);
    read = 4'b0000;
    drain(20);
    exp_q.push_back({1'b1, 2'd3, 8'hA3});
    exp_q.push_back({1'b0, 2'd2, 8'h5C});
    exp_q.push_back({1'b0, 2'd1, 8'h11});
    exp_q.push_back({1'b0, 2'd0, 8'h22});
    compare_words("ovf_drain");
    check("ovf_empty", out_valid, 32'd0);
    check("ovf_sticky", overflow, 32'd1);

    // ---------------- reset mid-frame ----------------
    convert = 1'b1;
    apply(4'b1100, 16'hA35C, 6);   // two words queued
    apply(4'b0011, 16'h1122, 2);   // next half-frame still settling
    check("midrst_pre_valid", out_valid, 32'd1);
    check("midrst_pre_dac", dac_code, 32'd8);
    reset = 1'b1;
    step();
    check("midrst_valid",    out_valid,  32'd0);
    check("midrst_dac",      dac_code,   32'd0);
    check("midrst_overflow", overflow,   32'd0);
    check("midrst_word",     {out_sof, out_idx, out_data}, 32'd0);
    check("midrst_fd",       frame_done, 32'd0);
    reset = 1'b0; convert = 1'b0;
    apply(4'b0000, 16'h0000, 6);
    check("midrst_lost", out_valid, 32'd0);
    // A fresh frame after reset: nothing before t0+4, first word at t0+4.
    apply(4'b1100, 16'h5AC3, 3);
    check("postrst_t0p3", out_valid, 32'd0);
    step();
    check("postrst_t0p4", {out_valid, out_sof, out_idx, out_data},
          {1'b1, 1'b1, 2'd3, 8'h5A});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
